// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - packs a byte stream into 32-bit words and loads instruction memory
// Holds the processor core in reset for the whole load and releases it once the last word is written.
module imem_program_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int RELEASE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, RELEASE} state_t;

   state_t                state, state_n;
   logic [1:0]            byte_idx, byte_idx_n;
   logic [ADDR_WIDTH:0]   count, count_n;
   logic [RW-1:0]         rel_cnt, rel_cnt_n;
   logic                  byte_ready_n, imem_we_n, core_reset_n, busy_n, done_n, error_n;
   logic [ADDR_WIDTH-1:0] imem_addr_n;
   logic [31:0]           imem_wdata_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         byte_idx   <= '0;
         count      <= '0;
         rel_cnt    <= '0;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         byte_idx   <= byte_idx_n;
         count      <= count_n;
         rel_cnt    <= rel_cnt_n;
         byte_ready <= byte_ready_n;
         imem_we    <= imem_we_n;
         imem_addr  <= imem_addr_n;
         imem_wdata <= imem_wdata_n;
         core_reset <= core_reset_n;
         busy       <= busy_n;
         done       <= done_n;
         error      <= error_n;
      end
   end

   always_comb begin
      state_n      = state;
      byte_idx_n   = byte_idx;
      count_n      = count;
      rel_cnt_n    = rel_cnt;
      byte_ready_n = byte_ready;
      imem_we_n    = 1'b0;
      imem_addr_n  = imem_addr;
      imem_wdata_n = imem_wdata;
      core_reset_n = core_reset;
      busy_n       = busy;
      done_n       = done;
      error_n      = error;
      case (state)
         IDLE: begin
            if (start) begin
               if (word_count != '0 && word_count <= MAX_WORDS) begin
                  count_n      = word_count;
                  imem_addr_n  = '0;
                  byte_idx_n   = '0;
                  busy_n       = 1'b1;
                  core_reset_n = 1'b1;
                  done_n       = 1'b0;
                  error_n      = 1'b0;
                  byte_ready_n = 1'b1;
                  state_n      = COLLECT;
               end else begin
                  error_n = 1'b1;
                  done_n  = 1'b0;
               end
            end
         end
         COLLECT: begin
            if (byte_valid && byte_ready) begin
               imem_wdata_n[{byte_idx, 3'b000} +: 8] = byte_data;
               byte_idx_n = byte_idx + 2'd1;
               if (byte_idx == 2'd3) begin
                  byte_ready_n = 1'b0;
                  imem_we_n    = 1'b1;
                  state_n      = WRITE;
               end
            end
         end
         WRITE: begin
            // Compare in ADDR_WIDTH+1 bits so a full-depth load ends without wrapping the address.
            if ({1'b0, imem_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1} == count) begin
               rel_cnt_n = '0;
               state_n   = RELEASE;
            end else begin
               imem_addr_n  = imem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
               byte_idx_n   = '0;
               byte_ready_n = 1'b1;
               state_n      = COLLECT;
            end
         end
         RELEASE: begin
            if (rel_cnt == RW'(RELEASE_CYCLES - 1)) begin
               core_reset_n = 1'b0;
               busy_n       = 1'b0;
               done_n       = 1'b1;
               state_n      = IDLE;
            end else begin
               rel_cnt_n = rel_cnt + {{(RW-1){1'b0}}, 1'b1};
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
// A second instance with ADDR_WIDTH=2 covers the full-depth load.
module tb_imem_program_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, start2 = 1'b0;
   logic [8:0]  word_count = '0;
   logic [2:0]  word_count2 = '0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;

   logic        byte_ready, imem_we, core_reset, busy, done, error;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        byte_ready2, imem_we2, core_reset2, busy2, done2, error2;
   logic [1:0]  imem_addr2;
   logic [31:0] imem_wdata2;

   int checks = 0;
   int errors = 0;
   int we_count = 0;
   logic [1:0]  wlog2_addr[$];
   logic [31:0] wlog2_data[$];

   always #5 clk = ~clk;

   imem_program_loader dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .busy(busy), .done(done), .error(error)
   );

   imem_program_loader #(.ADDR_WIDTH(2), .RELEASE_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .word_count(word_count2),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready2),
      .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
      .core_reset(core_reset2), .busy(busy2), .done(done2), .error(error2)
   );

   always @(negedge clk) begin
      if (imem_we === 1'b1) we_count++;
      if (imem_we2 === 1'b1) begin
         wlog2_addr.push_back(imem_addr2);
         wlog2_data.push_back(imem_wdata2);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b);
      int n = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (((sel ? byte_ready2 : byte_ready) !== 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("byte_ready_wait", {63'd0, sel ? byte_ready2 : byte_ready}, 64'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input bit sel, input logic [31:0] w, input int gap, input logic [7:0] exp_addr);
      for (int k = 0; k < 4; k++) begin
         repeat (gap) @(negedge clk);
         send_byte(sel, w[8*k +: 8]);
      end
      if (sel) begin
         check("we2_pulse", {63'd0, imem_we2}, 64'd1);
         check("we2_addr", {62'd0, imem_addr2}, {56'd0, exp_addr});
         check("we2_data", {32'd0, imem_wdata2}, {32'd0, w});
      end else begin
         check("we_pulse", {63'd0, imem_we}, 64'd1);
         check("we_addr", {56'd0, imem_addr}, {56'd0, exp_addr});
         check("we_data", {32'd0, imem_wdata}, {32'd0, w});
      end
   endtask

   task automatic check_release;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("rel_core_reset", {63'd0, core_reset}, (i < 3) ? 64'd1 : 64'd0);
         check("rel_done", {63'd0, done}, (i < 3) ? 64'd0 : 64'd1);
         check("rel_we", {63'd0, imem_we}, 64'd0);
      end
      check("rel_busy", {63'd0, busy}, 64'd0);
   endtask

   task automatic start_load(input logic [8:0] n);
      word_count = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      // 1: reset state, no start
      repeat (3) @(negedge clk);
      check("rst_core_reset", {63'd0, core_reset}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, byte_ready}, 64'd0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_core_reset", {63'd0, core_reset}, 64'd1);
      check("idle_done", {63'd0, done}, 64'd0);
      check("idle_error", {63'd0, error}, 64'd0);
      check("idle_no_we", we_count, 64'd0);

      // 2: two words back-to-back
      start_load(9'd2);
      check("start_busy", {63'd0, busy}, 64'd1);
      check("start_ready", {63'd0, byte_ready}, 64'd1);
      send_word(1'b0, 32'h0050_0513, 0, 8'd0);
      send_word(1'b0, 32'h00A0_0593, 0, 8'd1);
      check_release();
      check("t2_we_count", we_count, 64'd2);

      // 3: same stream with 3 idle cycles before every byte
      start_load(9'd2);
      check("reload_core_reset", {63'd0, core_reset}, 64'd1);
      check("reload_done_clr", {63'd0, done}, 64'd0);
      send_word(1'b0, 32'h0050_0513, 3, 8'd0);
      send_word(1'b0, 32'h00A0_0593, 3, 8'd1);
      check_release();
      check("t3_we_count", we_count, 64'd4);

      // 4: rejected starts leave core_reset and address alone
      start_load(9'd0);
      check("zero_error", {63'd0, error}, 64'd1);
      check("zero_busy", {63'd0, busy}, 64'd0);
      check("zero_done", {63'd0, done}, 64'd0);
      check("zero_core_reset", {63'd0, core_reset}, 64'd0);
      check("zero_addr", {56'd0, imem_addr}, 64'd1);
      start_load(9'd257);
      check("big_error", {63'd0, error}, 64'd1);
      check("big_busy", {63'd0, busy}, 64'd0);
      check("big_core_reset", {63'd0, core_reset}, 64'd0);

      // 5: start ignored mid-load, then reset after 5 bytes
      start_load(9'd3);
      check("t5_error_clr", {63'd0, error}, 64'd0);
      send_byte(1'b0, 8'hAA);
      send_byte(1'b0, 8'hBB);
      start_load(9'd0);
      check("midstart_error", {63'd0, error}, 64'd0);
      check("midstart_busy", {63'd0, busy}, 64'd1);
      check("midstart_ready", {63'd0, byte_ready}, 64'd1);
      send_byte(1'b0, 8'hCC);
      send_byte(1'b0, 8'hDD);
      check("t5_we_data", {32'd0, imem_wdata}, 64'hDDCC_BBAA);
      send_byte(1'b0, 8'hEE);
      reset = 1'b1;
      #1;
      check("abort_core_reset", {63'd0, core_reset}, 64'd1);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_ready", {63'd0, byte_ready}, 64'd0);
      check("abort_addr", {56'd0, imem_addr}, 64'd0);
      check("abort_wdata", {32'd0, imem_wdata}, 64'd0);
      check("abort_flags", {61'd0, imem_we, done, error}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 6: full-depth load on the ADDR_WIDTH=2 instance
      word_count2 = 3'd4;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      send_word(1'b1, 32'h1122_3344, 0, 8'd0);
      send_word(1'b1, 32'h5566_7788, 1, 8'd1);
      send_word(1'b1, 32'h99AA_BBCC, 0, 8'd2);
      send_word(1'b1, 32'hDEAD_BEEF, 2, 8'd3);
      for (int i = 0; i < 10 && done2 !== 1'b1; i++) @(negedge clk);
      check("full_done", {63'd0, done2}, 64'd1);
      check("full_core_reset", {63'd0, core_reset2}, 64'd0);
      repeat (5) @(negedge clk);
      check("full_we_count", wlog2_addr.size(), 64'd4);
      for (int i = 0; i < wlog2_addr.size(); i++)
         check("full_addr_seq", {62'd0, wlog2_addr[i]}, i);
      if (wlog2_data.size() == 4) check("full_last_data", {32'd0, wlog2_data[3]}, 64'hDEAD_BEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
